// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus generator: mode and FSM encodings,
// LFSR polynomial and seed, plus the single-step LFSR function.
package stim_pkg;

  typedef enum logic [1:0] {
    RANDOM   = 2'd0,
    WR_SWEEP = 2'd1,
    RD_SWEEP = 2'd2,
    WR_RD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/stim_gen_if.sv
// Downstream stimulus bus: one transaction (addr/wr/en) qualified by valid,
// accepted by ready.
interface stim_gen_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic              en;
  logic              valid;
  logic              ready;

  modport master (output addr, wr, en, valid, input ready);
  modport slave  (input addr, wr, en, valid, output ready);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps once per cycle with adv high; a zero seed
// would lock up, so it falls back to the default seed.
module lfsr16
  import stim_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] q
);

  localparam logic [15:0] RST_VAL = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic [15:0] q_q, q_d;

  always_comb q_d = adv ? lfsr_next(q_q) : q_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/stim_gen.sv
// Stimulus generator: on start, emits num_txn transactions in the selected
// mode over a valid/ready bus, then pulses done for one cycle.
module stim_gen
  import stim_pkg::*;
#(
  parameter int          ADDR_W = 6,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_txn,
  output logic             busy,
  output logic             done,
  stim_gen_if.master       bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              en;
  } txn_t;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] seq_q, seq_d;
  txn_t              txn_q, txn_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs;
  logic              lfsr_adv;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_nxt;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (lfsr_adv),
    .q   (lfsr_q)
  );

  // Outputs are registered, so the next transaction is built from the
  // post-handshake LFSR/seq/index values rather than the current ones.
  function automatic txn_t gen_txn(input mode_e m, input logic [15:0] rnd,
                                   input logic [ADDR_W-1:0] seq, input logic odd);
    txn_t t;
    case (m)
      RANDOM:   t = '{addr: rnd[ADDR_W-1:0], wr: rnd[8], en: rnd[9]};
      WR_SWEEP: t = '{addr: seq, wr: 1'b1, en: 1'b1};
      RD_SWEEP: t = '{addr: seq, wr: 1'b0, en: 1'b1};
      default:  t = '{addr: seq, wr: ~odd, en: 1'b1};
    endcase
    return t;
  endfunction

  assign hs       = valid_q & bus.ready;
  assign lfsr_nxt = lfsr_next(lfsr_q);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    txn_d    = '0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    lfsr_adv = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode_e'(mode);
          num_d  = num_txn;
          cnt_d  = '0;
          seq_d  = '0;
          if (num_txn != '0) begin
            state_d = RUN;
            valid_d = 1'b1;
            txn_d   = gen_txn(mode_e'(mode), lfsr_q, '0, 1'b0);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        valid_d = 1'b1;
        txn_d   = txn_q;
        if (hs) begin
          cnt_d    = cnt_q + 1'b1;
          lfsr_adv = (mode_q == RANDOM);
          // WR_RD revisits each address twice: seq moves on after the read.
          if (mode_q == WR_SWEEP || mode_q == RD_SWEEP || (mode_q == WR_RD && cnt_q[0]))
            seq_d = seq_q + 1'b1;
          if (cnt_d == num_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            txn_d   = '0;
          end else begin
            txn_d = gen_txn(mode_q, lfsr_nxt, seq_d, cnt_d[0]);
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= RANDOM;
      num_q   <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      txn_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      txn_q   <= txn_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.addr  = txn_q.addr;
  assign bus.wr    = txn_q.wr;
  assign bus.en    = txn_q.en;
  assign bus.valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/stim_gen.md
STIM_GEN -- requirements
Module: stim_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, address width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, transaction-counter width.
REQ-003 SHALL have parameter SEED, default 16'hACE1, LFSR reset value; a SEED of 0 SHALL be replaced by 16'hACE1.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, begin a run; sampled only in IDLE.
REQ-007 SHALL have port mode, input, 2, stimulus mode; sampled with start.
REQ-008 SHALL have port num_txn, input, CNT_W, transactions per run; sampled with start.
REQ-009 SHALL have port ready, input, 1, downstream accept.
REQ-010 SHALL have port addr, output, ADDR_W, stimulus address.
REQ-011 SHALL have port wr, output, 1, write (1) or read (0).
REQ-012 SHALL have port en, output, 1, access enable.
REQ-013 SHALL have port valid, output, 1, addr/wr/en are presented.
REQ-014 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at end of run.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DONE.
REQ-017 IDLE with start=1 SHALL latch mode and num_txn, clear the txn count and sequential address to 0, and go to RUN if num_txn!=0, else to DONE.
REQ-018 In RUN, valid SHALL be 1 and the first transaction SHALL appear on the cycle after start is sampled.
REQ-019 A handshake is valid&&ready; each handshake SHALL advance to the next transaction and increment the txn count.
REQ-020 While valid=1 and ready=0, addr/wr/en SHALL hold stable.
REQ-021 When the handshake completing transaction num_txn occurs, the FSM SHALL go to DONE and valid SHALL drop on the next cycle.
REQ-022 DONE SHALL last exactly one cycle with done=1 and valid=0, then return to IDLE.
REQ-023 start SHALL be ignored in RUN and DONE.
REQ-024 Mode 0 (RANDOM) SHALL take addr=lfsr[ADDR_W-1:0], wr=lfsr[8], en=lfsr[9], with the LFSR advancing once per handshake in this mode only.
REQ-025 The LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1; it SHALL NOT be reloaded by start.
REQ-026 Mode 1 (WR_SWEEP) SHALL give addr=seq, wr=1, en=1, with seq incrementing per handshake.
REQ-027 Mode 2 (RD_SWEEP) SHALL give addr=seq, wr=0, en=1, with seq incrementing per handshake.
REQ-028 Mode 3 (WR_RD) SHALL give even-indexed txns as write to seq and odd-indexed txns as read from the same seq, with seq incrementing after each read; en=1.
REQ-029 seq SHALL wrap from 2^ADDR_W-1 to 0; addr SHALL never exceed 2^ADDR_W-1.
REQ-030 When valid=0, addr/wr/en SHALL be 0.

Reset
REQ-031 rst SHALL immediately force IDLE, lfsr=SEED (or 16'hACE1 if SEED is 0), and count, seq, addr, wr, en, valid, busy, done all to 0.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse.

Structure
REQ-033 Package stim_pkg SHALL hold the mode enum (RANDOM, WR_SWEEP, RD_SWEEP, WR_RD), the FSM state enum, the LFSR taps constant and the default seed.
REQ-034 The LFSR SHALL be a sub-module lfsr16 with ports clk, rst, adv and q.

Verification
REQ-035 With ADDR_W=6, mode 1, num_txn=4 and ready=1, the bench SHALL check addr 0,1,2,3 with wr=1 and en=1 on 4 consecutive cycles, then done=1 for one cycle.
REQ-036 With mode 1 and num_txn=66, the bench SHALL check that the txn at index 63 has addr=63 and the txn at index 64 has addr=0.
REQ-037 With mode 2, the bench SHALL hold ready=0 for 3 cycles on txn 1 and check that addr=1, wr=0 stays stable, then that txn 2 follows on the cycle after ready=1.
REQ-038 With mode 3 and num_txn=4, the bench SHALL check the sequence (0,wr=1), (0,wr=0), (1,wr=1), (1,wr=0).
REQ-039 With num_txn=0, the bench SHALL check that valid never rises, done=1 occurs once, and the FSM is back in IDLE.
REQ-040 With mode 0 after reset, the bench SHALL check that the first 8 transactions match the reference LFSR model, then assert rst mid-run and check that all outputs are 0 asynchronously with no done pulse.
